relu_maxpool: RTL and testbench
===============================

RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 Parameters SHALL be: FMAP_WIDTH, 26, outfmap columns; FMAP_HEIGHT, 26, outfmap rows; NUM_FEATURES, 10, parallel feature maps; DATA_WIDTH, 32, signed pixel width.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_pool  in  1  asynchronous active-low reset.
REQ-004 clr  in  1  synchronous frame abort; active-high.
REQ-005 in_valid  in  1  in_data holds one outfmap pixel position.
REQ-006 in_ready  out  1  block accepts in_data this cycle.
REQ-007 in_data  in  NUM_FEATURES x DATA_WIDTH  signed conv sums for all features at one position, raster order.
REQ-008 out_valid  out  1  out_data holds a pooled result.
REQ-009 out_ready  in  1  consumer accepts out_data this cycle.
REQ-010 out_data  out  NUM_FEATURES x DATA_WIDTH  pooled values, non-negative.
REQ-011 out_row, out_col  out  $clog2(FMAP_HEIGHT/2+1) and $clog2(FMAP_WIDTH/2+1)  pooled coordinates of out_data.
REQ-012 frame_done  out  1  one-cycle pulse when the last pooled result of a frame is accepted.

Function
REQ-013 Transfer on either port SHALL occur only when valid and ready are both high in the same cycle.
REQ-014 ReLU SHALL map each signed input value v to max(v,0) before pooling.
REQ-015 Pooling SHALL be 2x2 max, stride 2, per feature; output grid floor(FMAP_WIDTH/2) x floor(FMAP_HEIGHT/2); a trailing odd column or row SHALL be consumed and discarded.
REQ-016 Input column/row counters SHALL advance per accepted pixel; column wraps at FMAP_WIDTH-1 to 0 and increments row; row wraps at FMAP_HEIGHT-1 to 0 (next frame).
REQ-017 FSM states: ROW_EVEN, ROW_ODD, ROW_SKIP; reset state ROW_EVEN.
REQ-018 ROW_EVEN: even column -> hold ReLU pixel in hreg; odd column -> write max(hreg,pixel) to line buffer entry col/2; at row end -> ROW_ODD.
REQ-019 ROW_ODD: even column -> hold in hreg; odd column -> load output register with max(linebuf[col/2],hreg,pixel) and set out_valid; at row end -> ROW_SKIP if next row is FMAP_HEIGHT-1 and FMAP_HEIGHT odd, else ROW_EVEN.
REQ-020 ROW_SKIP: accept and discard pixels; at row end -> ROW_EVEN.
REQ-021 Latency: out_valid SHALL rise the cycle after the completing pixel is accepted.
REQ-022 Output register is one entry: in_ready = !(out_valid && !out_ready); a full register with out_ready high SHALL accept a new pixel in the same cycle (back-to-back).
REQ-023 out_data, out_row, out_col SHALL remain stable while out_valid && !out_ready.
REQ-024 frame_done SHALL pulse in the cycle the result at (FMAP_HEIGHT/2-1, FMAP_WIDTH/2-1) transfers.
REQ-025 clr SHALL return FSM to ROW_EVEN, zero counters, drop out_valid; clr has priority over a simultaneous input transfer; line buffer contents need not be cleared.
REQ-026 Comparisons SHALL be signed DATA_WIDTH; no width growth; ReLU output 0 on most-negative input.

Reset
REQ-027 While rst_pool low: state ROW_EVEN, counters 0, hreg 0, out_valid 0, out_data 0, out_row 0, out_col 0, frame_done 0, in_ready 1.
REQ-028 Reset mid-frame SHALL abandon the frame; first pixel after release is treated as (0,0).

Structure
REQ-029 Package cnn_pkg SHALL hold DATA_WIDTH default, pixel_t (signed DATA_WIDTH), and the FSM state enum.
REQ-030 Sub-module max_relu2 (signed two-input max) SHALL be instantiated per feature for the hreg/linebuf comparisons.
REQ-031 Line buffer SHALL be NUM_FEATURES x FMAP_WIDTH/2 registers.

Verification
REQ-032 4x4 map, feature0 = 1..16 raster, out_ready=1 -> outputs 6,8,14,16 at (0,0),(0,1),(1,0),(1,1); frame_done with fourth.
REQ-033 All inputs -5 except one 3 per window -> each output 3; all -5 -> outputs 0.
REQ-034 5x5 map, values 1..25 -> outputs 7,9,17,19; row 4 and column 4 discarded; next frame starts cleanly.
REQ-035 out_ready held low 5 cycles on first result -> in_ready low after the next completing pixel, out_data stable, no loss.
REQ-036 clr asserted mid row 1 with in_valid high -> out_valid 0 next cycle, restart at (0,0) produces correct 4x4 results.
REQ-037 rst_pool pulsed asynchronously mid-frame -> all outputs 0 immediately, subsequent frame correct.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types for the CNN post-processing blocks.
// Holds the default pixel width, pixel type and pooling FSM states.
package cnn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        ROW_EVEN = 2'd0,
        ROW_ODD  = 2'd1,
        ROW_SKIP = 2'd2
    } row_state_e;

endpackage

// File: rtl/max_relu2.sv
// Signed two-input maximum used for the horizontal and vertical
// halves of each 2x2 pooling window.
module max_relu2
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y
);

    assign y = (a > b) ? a : b;

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2/stride-2 max pooling over raster-order pixels,
// with one line buffer row of pair maxima and a one-entry output reg.
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int FMAP_WIDTH   = 26,
    parameter int FMAP_HEIGHT  = 26,
    parameter int NUM_FEATURES = 10,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    localparam int ROW_W = $clog2(FMAP_HEIGHT/2+1),
    localparam int COL_W = $clog2(FMAP_WIDTH/2+1)
) (
    input  logic                                   clk,
    input  logic                                   rst_pool,
    input  logic                                   clr,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0] in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0] out_data,
    output logic [ROW_W-1:0]                       out_row,
    output logic [COL_W-1:0]                       out_col,
    output logic                                   frame_done
);

    localparam int CW     = $clog2(FMAP_WIDTH+1);
    localparam int RW     = $clog2(FMAP_HEIGHT+1);
    localparam int HALF_W = FMAP_WIDTH/2;
    localparam bit H_ODD  = (FMAP_HEIGHT % 2) == 1;

    row_state_e state;
    row_state_e state_nxt;

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [COL_W-1:0] lb_idx;
    logic             accept;
    logic             row_end;
    logic             col_odd;
    logic             last_row;

    logic signed [DATA_WIDTH-1:0] px    [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] hreg  [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] hmax  [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] lb_rd [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] pool  [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] lbuf  [HALF_W][NUM_FEATURES];

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign row_end  = (col == CW'(FMAP_WIDTH-1));
    assign last_row = (row == RW'(FMAP_HEIGHT-1));
    assign col_odd  = col[0];
    assign lb_idx   = COL_W'(col >> 1);

    assign frame_done = out_valid && out_ready
                     && (out_row == ROW_W'(FMAP_HEIGHT/2-1))
                     && (out_col == COL_W'(FMAP_WIDTH/2-1));

    for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
        // Sign bit set means negative: ReLU clamps it to zero.
        assign px[f] = in_data[f][DATA_WIDTH-1] ? '0 : $signed(in_data[f]);
        assign lb_rd[f] = lbuf[lb_idx][f];

        max_relu2 #(.DATA_WIDTH(DATA_WIDTH)) u_hmax (
            .a (hreg[f]),
            .b (px[f]),
            .y (hmax[f])
        );

        max_relu2 #(.DATA_WIDTH(DATA_WIDTH)) u_vmax (
            .a (lb_rd[f]),
            .b (hmax[f]),
            .y (pool[f])
        );
    end

    always_ff @(posedge clk or negedge rst_pool) begin
        if (!rst_pool) begin
            state <= ROW_EVEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ROW_EVEN;
        end else if (accept && row_end) begin
            case (state)
                ROW_EVEN: state_nxt = ROW_ODD;
                ROW_ODD: begin
                    if (H_ODD && row == RW'(FMAP_HEIGHT-2)) begin
                        state_nxt = ROW_SKIP;
                    end else begin
                        state_nxt = ROW_EVEN;
                    end
                end
                default: state_nxt = ROW_EVEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_pool) begin
        if (!rst_pool) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            for (int f = 0; f < NUM_FEATURES; f++) begin
                hreg[f] <= '0;
            end
        end else if (clr) begin
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (row_end) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (state != ROW_SKIP && !col_odd) begin
                    for (int f = 0; f < NUM_FEATURES; f++) begin
                        hreg[f] <= px[f];
                    end
                end
                if (state == ROW_ODD && col_odd) begin
                    out_valid <= 1'b1;
                    out_row   <= ROW_W'(row >> 1);
                    out_col   <= lb_idx;
                    for (int f = 0; f < NUM_FEATURES; f++) begin
                        out_data[f] <= pool[f];
                    end
                end
            end
        end
    end

    // Contents are don't-care after reset or clr, so no reset branch.
    always_ff @(posedge clk) begin
        if (accept && !clr && state == ROW_EVEN && col_odd) begin
            for (int f = 0; f < NUM_FEATURES; f++) begin
                lbuf[lb_idx][f] <= hmax[f];
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: a 4x4 and a 5x5 instance share
// stimulus; sel5 picks which one is driven and observed.
module tb_relu_maxpool;

    logic        clk;
    logic        rst_pool;
    logic        clr;
    logic        in_valid;
    logic        out_ready;
    logic        sel5;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0][31:0] din;

    logic             rdy4, ov4, fd4, rdy5, ov5, fd5;
    logic [1:0][31:0] od4, od5;
    logic [1:0]       orow4, ocol4, orow5, ocol5;

    logic             rdy, ov, fd;
    logic [1:0][31:0] od;
    logic [1:0]       orow, ocol;

    assign din  = {d1, d0};
    assign rdy  = sel5 ? rdy5 : rdy4;
    assign ov   = sel5 ? ov5 : ov4;
    assign fd   = sel5 ? fd5 : fd4;
    assign od   = sel5 ? od5 : od4;
    assign orow = sel5 ? orow5 : orow4;
    assign ocol = sel5 ? ocol5 : ocol4;

    relu_maxpool #(
        .FMAP_WIDTH(4), .FMAP_HEIGHT(4),
        .NUM_FEATURES(2), .DATA_WIDTH(32)
    ) u4 (
        .clk(clk), .rst_pool(rst_pool), .clr(clr),
        .in_valid(in_valid && !sel5), .in_ready(rdy4),
        .in_data(din), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .out_row(orow4), .out_col(ocol4),
        .frame_done(fd4)
    );

    relu_maxpool #(
        .FMAP_WIDTH(5), .FMAP_HEIGHT(5),
        .NUM_FEATURES(2), .DATA_WIDTH(32)
    ) u5 (
        .clk(clk), .rst_pool(rst_pool), .clr(clr),
        .in_valid(in_valid && sel5), .in_ready(rdy5),
        .in_data(din), .out_valid(ov5), .out_ready(out_ready),
        .out_data(od5), .out_row(orow5), .out_col(ocol5),
        .frame_done(fd5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v0;
        logic [31:0] v1;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        f;
    } res_t;

    typedef struct {
        int px [16];
        int ex [4];
    } vec_t;

    res_t q[$];
    vec_t tbl [4];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge clk) begin
        if (rst_pool && ov && out_ready) begin
            q.push_back('{od[0], od[1], orow, ocol, fd});
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic send(input int a, input int b);
        bit took;
        int n;
        in_valid = 1'b1;
        d0 = a;
        d1 = b;
        took = 1'b0;
        n = 0;
        while (!took && n < 50) begin
            @(negedge clk);
            took = rdy;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!took) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_results(input string tag, input int e0 [4],
                                 input int e1 [4]);
        int n;
        res_t r;
        n = 0;
        while (q.size() < 4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_count"}, q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (q.size() > 0) begin
                r = q.pop_front();
                chk($sformatf("%s_f0_%0d", tag, k), r.v0, e0[k]);
                chk($sformatf("%s_f1_%0d", tag, k), r.v1, e1[k]);
                chk($sformatf("%s_row_%0d", tag, k), {30'd0, r.r}, k / 2);
                chk($sformatf("%s_col_%0d", tag, k), {30'd0, r.c}, k % 2);
                chk($sformatf("%s_done_%0d", tag, k), {31'd0, r.f},
                    (k == 3) ? 1 : 0);
            end
        end
    endtask

    task automatic send_ramp4();
        for (int i = 0; i < 16; i++) send(i + 1, 16 - i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0 [4];
        int e1 [4];
        int ramp0 [4];
        int ramp1 [4];

        for (int i = 0; i < 16; i++) begin
            tbl[0].px[i] = i + 1;
            tbl[1].px[i] = -5;
            tbl[2].px[i] = -5;
        end
        tbl[1].px[0]  = 3;
        tbl[1].px[7]  = 3;
        tbl[1].px[13] = 3;
        tbl[1].px[10] = 3;
        tbl[3].px = '{32'sh8000_0000, -1, 32'sh7fff_ffff, 5,
                      -7, 0, 6, -1, 10, -100, -3, 2, 40, 30, -3, 1};
        tbl[0].ex = '{6, 8, 14, 16};
        tbl[1].ex = '{3, 3, 3, 3};
        tbl[2].ex = '{0, 0, 0, 0};
        tbl[3].ex = '{0, 32'sh7fff_ffff, 40, 2};
        ramp0 = '{6, 8, 14, 16};
        ramp1 = '{16, 14, 8, 6};

        rst_pool  = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel5      = 1'b0;
        d0        = '0;
        d1        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, rdy}, 1);
        chk("rst_valid", {31'd0, ov}, 0);
        chk("rst_data0", od[0], 0);
        chk("rst_row", {30'd0, orow}, 0);
        chk("rst_col", {30'd0, ocol}, 0);
        chk("rst_done", {31'd0, fd}, 0);
        rst_pool = 1'b1;
        @(posedge clk);
        #1;

        // Feature 1 carries the raster-mirrored frame, so its window w
        // holds the same values as feature 0's window 3-w.
        for (int t = 0; t < 4; t++) begin
            q.delete();
            for (int i = 0; i < 16; i++) begin
                send(tbl[t].px[i], tbl[t].px[15-i]);
            end
            for (int w = 0; w < 4; w++) begin
                e0[w] = tbl[t].ex[w];
                e1[w] = tbl[t].ex[3-w];
            end
            check_results($sformatf("vec%0d", t), e0, e1);
        end

        q.delete();
        fork
            send_ramp4();
            begin
                int n;
                n = 0;
                while (!ov && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("bp_first_valid", {31'd0, ov}, 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    chk("bp_hold_data", od[0], 6);
                    chk("bp_hold_valid", {31'd0, ov}, 1);
                    chk("bp_in_ready", {31'd0, rdy}, 0);
                end
                out_ready = 1'b1;
            end
        join
        check_results("bp", ramp0, ramp1);

        q.delete();
        for (int i = 0; i < 6; i++) send(i + 1, 16 - i);
        chk("clr_pre_valid", {31'd0, ov}, 1);
        in_valid = 1'b1;
        d0 = 7;
        d1 = 10;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", {31'd0, ov}, 0);
        q.delete();
        send_ramp4();
        check_results("clr", ramp0, ramp1);

        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(i + 1, 16 - i);
        chk("ar_pre_data", od[0], 6);
        #3;
        rst_pool = 1'b0;
        #1;
        chk("ar_valid", {31'd0, ov}, 0);
        chk("ar_data0", od[0], 0);
        chk("ar_data1", od[1], 0);
        chk("ar_row", {30'd0, orow}, 0);
        chk("ar_col", {30'd0, ocol}, 0);
        chk("ar_ready", {31'd0, rdy}, 1);
        @(posedge clk);
        #3;
        rst_pool = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        send_ramp4();
        check_results("ar", ramp0, ramp1);

        sel5 = 1'b1;
        q.delete();
        for (int i = 0; i < 25; i++) send(i + 1, 25 - i);
        e0 = '{7, 9, 17, 19};
        e1 = '{25, 23, 15, 13};
        check_results("odd_f1", e0, e1);
        repeat (3) @(posedge clk);
        #1;
        chk("odd_no_extra", q.size(), 0);
        for (int i = 0; i < 25; i++) send(i + 101, 25 - i);
        e0 = '{107, 109, 117, 119};
        check_results("odd_f2", e0, e1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
